// File: rtl/ddma_send_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : ddma_send_sched_if
//  Description : Bundle of the descriptor push port, the ddma send channel
//                and the CPU-visible status lines used by ddma_send_sched.
//                - slave  : the scheduler itself
//                - master : whatever drives it (CPU regs + ddma model)
//  Signals     : push_valid/ready/addr/size/dest, flush   (descriptor side)
//                send_addr/size/dest_out, send_cmd_out,
//                irq_send_in                              (ddma side)
//                level_out, done_count_out, irq_done_out,
//                irq_ack, err_out                         (status side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ddma_send_sched_if #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int c_LVL_W = $clog2(DEPTH + 1);

    logic                  push_valid;
    logic                  push_ready;
    logic [FLIT_WIDTH-1:0] push_addr;
    logic [FLIT_WIDTH-1:0] push_size;
    logic [FLIT_WIDTH-1:0] push_dest;
    logic                  flush;

    logic [FLIT_WIDTH-1:0] send_addr_out;
    logic [FLIT_WIDTH-1:0] send_size_out;
    logic [FLIT_WIDTH-1:0] send_dest_out;
    logic                  send_cmd_out;
    logic                  irq_send_in;

    logic [c_LVL_W-1:0]    level_out;
    logic [15:0]           done_count_out;
    logic                  irq_done_out;
    logic                  irq_ack;
    logic                  err_out;

    modport slave (
        input  push_valid, push_addr, push_size, push_dest, flush,
        input  irq_send_in, irq_ack,
        output push_ready,
        output send_addr_out, send_size_out, send_dest_out, send_cmd_out,
        output level_out, done_count_out, irq_done_out, err_out
    );

    modport master (
        output push_valid, push_addr, push_size, push_dest, flush,
        output irq_send_in, irq_ack,
        input  push_ready,
        input  send_addr_out, send_size_out, send_dest_out, send_cmd_out,
        input  level_out, done_count_out, irq_done_out, err_out
    );
endinterface
`default_nettype wire

// File: rtl/ddma_send_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ddma_send_sched
//  Description : Descriptor FIFO and sequencer in front of the ddma send
//                channel. Queued descriptors are replayed one at a time:
//                load registers, raise cmd, wait for the send irq, drop cmd,
//                wait for the irq to clear. The CPU only sees a completion
//                counter, a sticky interrupt and the queue level.
//  Ports       : clock  - system clock
//                reset  - synchronous, active-low
//                bus    - ddma_send_sched_if.slave (push port, ddma send
//                         channel, status/interrupt lines)
//  Parameters  : FLIT_WIDTH      - word width of addr/size/dest
//                DEPTH           - FIFO entries (power of two, >= 2)
//                WATCHDOG_CYCLES - S_BUSY cycle limit (watchdog builds only)
//  Options     : define DDMAQ_WATCHDOG_EN to enable the S_BUSY watchdog;
//                without it err_out is tied low and S_BUSY waits forever.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddma_send_sched #(
    parameter int FLIT_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int WATCHDOG_CYCLES = 65535
) (
    input  wire logic          clock,
    input  wire logic          reset,
    ddma_send_sched_if.slave   bus
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_LVL_W = $clog2(DEPTH + 1);
    localparam logic [c_LVL_W-1:0] c_FULL  = c_LVL_W'(DEPTH);

    // Reject configurations the pointer arithmetic cannot handle.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
            (WATCHDOG_CYCLES < 1) || (WATCHDOG_CYCLES > 65535)) begin : g_bad_param
            $error("ddma_send_sched: DEPTH must be a power of two >= 2 and WATCHDOG_CYCLES in 1..65535");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_BUSY  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Descriptor storage
    // ------------------------------------------------------------------------
    logic [FLIT_WIDTH-1:0] r_mem_addr [DEPTH];
    logic [FLIT_WIDTH-1:0] r_mem_size [DEPTH];
    logic [FLIT_WIDTH-1:0] r_mem_dest [DEPTH];

    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_LVL_W-1:0]    r_level;

    logic [FLIT_WIDTH-1:0] r_send_addr;
    logic [FLIT_WIDTH-1:0] r_send_size;
    logic [FLIT_WIDTH-1:0] r_send_dest;
    logic                  r_cmd;
    logic [15:0]           r_done_cnt;
    logic                  r_irq_done;

    logic                  w_push;
    logic                  w_empty;
    logic                  w_load;
    logic                  w_timeout;
    logic                  w_pop_ok;
    logic                  w_pop_wd;
    logic                  w_pop;
    logic                  w_keep;
    logic [c_LVL_W-1:0]    w_lvl_after_pop;
    logic [c_PTR_W-1:0]    w_head_nxt;

    assign bus.push_ready = (r_level != c_FULL) && !bus.flush;
    assign w_push         = bus.push_valid && bus.push_ready;
    assign w_empty        = (r_level == '0);

    // A normal completion has priority over a watchdog expiry in the same
    // cycle. Either way the in-flight head leaves the queue.
    assign w_pop_ok = (r_state == S_BUSY) && bus.irq_send_in;
    assign w_pop_wd = (r_state == S_BUSY) && !bus.irq_send_in && w_timeout;
    assign w_pop    = w_pop_ok || w_pop_wd;

    assign w_lvl_after_pop = r_level - c_LVL_W'(w_pop);
    assign w_head_nxt      = r_head + c_PTR_W'(w_pop);

    // Outside S_IDLE a flush spares the entry at the head of the queue
    // (the one in flight, or the next one while draining), if any remain.
    assign w_keep = (r_state != S_IDLE) && (w_lvl_after_pop != '0);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A flush in S_IDLE empties the whole queue, so dispatch is
                // held off for that cycle rather than launching a dead entry.
                if (!w_empty && !bus.irq_send_in && !bus.flush) begin
                    w_state_nxt = S_LOAD;
                    w_load      = 1'b1;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (w_pop) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!bus.irq_send_in) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and level
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            r_head <= w_head_nxt;
            if (bus.flush) begin
                // push_ready is low during a flush, so no push competes here.
                r_tail  <= w_head_nxt + c_PTR_W'(w_keep);
                r_level <= c_LVL_W'(w_keep);
            end else begin
                r_tail  <= r_tail + c_PTR_W'(w_push);
                r_level <= w_lvl_after_pop + c_LVL_W'(w_push);
            end
        end
    end

    // Storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_addr[r_tail] <= bus.push_addr;
            r_mem_size[r_tail] <= bus.push_size;
            r_mem_dest[r_tail] <= bus.push_dest;
        end
    end

    // ------------------------------------------------------------------------
    // ddma send registers. They change only on S_IDLE->S_LOAD, so they are
    // stable for the whole time cmd is high.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_send_addr <= '0;
            r_send_size <= '0;
            r_send_dest <= '0;
            r_cmd       <= 1'b0;
        end else begin
            if (w_load) begin
                r_send_addr <= r_mem_addr[r_head];
                r_send_size <= r_mem_size[r_head];
                r_send_dest <= r_mem_dest[r_head];
            end
            r_cmd <= (w_state_nxt == S_BUSY);
        end
    end

    // ------------------------------------------------------------------------
    // Completion counter and sticky interrupt (set beats ack)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_done_cnt <= '0;
            r_irq_done <= 1'b0;
        end else begin
            if (w_pop_ok) begin
                r_done_cnt <= r_done_cnt + 16'd1;
            end
            if (w_pop_ok) begin
                r_irq_done <= 1'b1;
            end else if (bus.irq_ack) begin
                r_irq_done <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional S_BUSY watchdog
    // ------------------------------------------------------------------------
`ifdef DDMAQ_WATCHDOG_EN
    localparam logic [15:0] c_WD_LAST = 16'(WATCHDOG_CYCLES - 1);

    logic [15:0] r_wd_cnt;
    logic        r_err;

    // The counter holds the number of S_BUSY cycles already completed, so
    // expiry fires during the WATCHDOG_CYCLES-th cycle of S_BUSY.
    assign w_timeout = (r_wd_cnt == c_WD_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_wd_cnt <= '0;
            end else if (r_state == S_BUSY) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end
            if (w_pop_wd) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.err_out = r_err;
`else
    assign w_timeout   = 1'b0;
    assign bus.err_out = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign bus.send_addr_out  = r_send_addr;
    assign bus.send_size_out  = r_send_size;
    assign bus.send_dest_out  = r_send_dest;
    assign bus.send_cmd_out   = r_cmd;
    assign bus.level_out      = r_level;
    assign bus.done_count_out = r_done_cnt;
    assign bus.irq_done_out   = r_irq_done;

endmodule
`default_nettype wire

// File: tb/tb_ddma_send_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddma_send_sched
//  Description : Self-checking bench for ddma_send_sched. A queue-based
//                reference model of the descriptor scheduler runs alongside
//                the DUT; a small ddma responder answers cmd with irq.
//                Directed scenarios cover latency, full FIFO, push/pop in
//                the same cycle, flush, irq set/ack race, watchdog (when
//                DDMAQ_WATCHDOG_EN is defined) and reset mid-send, followed
//                by a randomized soak.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddma_send_sched;

    localparam int FW    = 32;
    localparam int DEPTH = 4;
`ifdef DDMAQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
    localparam int WD    = 50;
`else
    localparam bit WD_EN = 1'b0;
    localparam int WD    = 65535;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_BUSY  = 2;
    localparam int P_DRAIN = 3;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] s;
        logic [31:0] d;
    } desc_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    ddma_send_sched_if #(.FLIT_WIDTH(FW), .DEPTH(DEPTH)) bus ();

    ddma_send_sched #(
        .FLIT_WIDTH      (FW),
        .DEPTH           (DEPTH),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    desc_t m_q[$];
    int    m_phase = P_IDLE;
    desc_t m_out   = '0;
    int    m_done  = 0;
    bit    m_irq   = 1'b0;
    bit    m_err   = 1'b0;
    int    m_wd    = 0;

    // ddma responder and monitor state
    bit    resp_on   = 1'b0;
    bit    resp_rand = 1'b0;
    int    resp_hi   = 0;
    int    resp_lo   = 0;
    int    resp_cnt  = 0;
    bit    prev_cmd  = 1'b0;
    logic [31:0] obs[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference model, using the inputs the bench
    // is currently driving.
    task automatic model_step();
        bit    push;
        bit    pop;
        bit    good;
        int    old_phase;
        int    keep;
        if (!reset) begin
            m_q.delete();
            m_phase = P_IDLE;
            m_out   = '0;
            m_done  = 0;
            m_irq   = 1'b0;
            m_err   = 1'b0;
            m_wd    = 0;
            return;
        end
        push      = bus.push_valid && (m_q.size() != DEPTH) && !bus.flush;
        pop       = 1'b0;
        good      = 1'b0;
        old_phase = m_phase;
        case (m_phase)
            P_IDLE: if (m_q.size() > 0 && !bus.irq_send_in && !bus.flush) begin
                m_out   = m_q[0];
                m_phase = P_LOAD;
            end
            P_LOAD: begin
                m_phase = P_BUSY;
                m_wd    = 0;
            end
            P_BUSY: begin
                if (bus.irq_send_in) begin
                    pop = 1'b1; good = 1'b1; m_phase = P_DRAIN;
                end else if (WD_EN && m_wd == WD - 1) begin
                    pop = 1'b1; m_err = 1'b1; m_phase = P_DRAIN;
                end else begin
                    m_wd++;
                end
            end
            default: if (!bus.irq_send_in) m_phase = P_IDLE;
        endcase
        if (pop) void'(m_q.pop_front());
        if (bus.flush) begin
            keep = (old_phase != P_IDLE && m_q.size() > 0) ? 1 : 0;
            while (m_q.size() > keep) void'(m_q.pop_back());
        end
        if (push) m_q.push_back('{bus.push_addr, bus.push_size, bus.push_dest});
        if (good) begin
            m_done = (m_done + 1) % 65536;
            m_irq  = 1'b1;
        end else if (bus.irq_ack) begin
            m_irq = 1'b0;
        end
    endtask

    task automatic check_all();
        check_eq("level",      32'(bus.level_out),      32'(m_q.size()));
        check_eq("cmd",        32'(bus.send_cmd_out),   32'(m_phase == P_BUSY));
        check_eq("done_count", 32'(bus.done_count_out), 32'(m_done));
        check_eq("irq_done",   32'(bus.irq_done_out),   32'(m_irq));
        check_eq("err",        32'(bus.err_out),        32'(m_err));
        check_eq("push_ready", 32'(bus.push_ready),     32'((m_q.size() != DEPTH) && !bus.flush));
        check_eq("send_addr",  bus.send_addr_out,       m_out.a);
        check_eq("send_size",  bus.send_size_out,       m_out.s);
        check_eq("send_dest",  bus.send_dest_out,       m_out.d);
    endtask

    task automatic responder();
        if (!resp_on) begin
            resp_cnt = 0;
            return;
        end
        if (bus.send_cmd_out && !bus.irq_send_in) begin
            if (resp_cnt >= resp_hi) begin
                bus.irq_send_in = 1'b1;
                resp_cnt = 0;
            end else begin
                resp_cnt++;
            end
        end else if (!bus.send_cmd_out && bus.irq_send_in) begin
            if (resp_cnt >= resp_lo) begin
                bus.irq_send_in = 1'b0;
                resp_cnt = 0;
                if (resp_rand) begin
                    resp_hi = $urandom_range(0, 8);
                    resp_lo = $urandom_range(0, 4);
                end
            end else begin
                resp_cnt++;
            end
        end else begin
            resp_cnt = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
        if (bus.send_cmd_out && !prev_cmd) begin
            obs.push_back(bus.send_addr_out);
            check_eq("cmd_rise_irq_low", 32'(bus.irq_send_in), 32'd0);
        end
        prev_cmd = bus.send_cmd_out;
        responder();
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] s, input logic [31:0] d);
        bus.push_valid = 1'b1;
        bus.push_addr  = a;
        bus.push_size  = s;
        bus.push_dest  = d;
        cycle();
        bus.push_valid = 1'b0;
    endtask

    task automatic wait_cmd(input string tag);
        int n;
        n = 0;
        while (!bus.send_cmd_out && n < 60) begin
            cycle();
            n++;
        end
        check_eq(tag, 32'(bus.send_cmd_out), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (n < 500 && !(m_q.size() == 0 && m_phase == P_IDLE &&
                            !bus.irq_send_in && !bus.send_cmd_out)) begin
            cycle();
            n++;
        end
        check_eq(tag, 32'(bus.level_out), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int done_before;
        bus.push_valid  = 1'b0;
        bus.push_addr   = '0;
        bus.push_size   = '0;
        bus.push_dest   = '0;
        bus.flush       = 1'b0;
        bus.irq_send_in = 1'b0;
        bus.irq_ack     = 1'b0;

        // ---- reset ----
        reset = 1'b0;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        check_eq("rst_level", 32'(bus.level_out),      32'd0);
        check_eq("rst_done",  32'(bus.done_count_out), 32'd0);
        check_eq("rst_cmd",   32'(bus.send_cmd_out),   32'd0);
        check_eq("rst_irq",   32'(bus.irq_done_out),   32'd0);
        check_eq("rst_err",   32'(bus.err_out),        32'd0);
        check_eq("rst_addr",  bus.send_addr_out,       32'd0);

        // ---- single send with fixed ddma latency ----
        resp_on = 1'b1; resp_hi = 20; resp_lo = 2;
        push_one(32'h100, 32'd3, 32'h0011);
        cycle();
        check_eq("lat_t2_cmd", 32'(bus.send_cmd_out), 32'd0);
        cycle();
        check_eq("lat_t3_cmd", 32'(bus.send_cmd_out), 32'd1);
        check_eq("single_addr", bus.send_addr_out, 32'h100);
        check_eq("single_size", bus.send_size_out, 32'd3);
        check_eq("single_dest", bus.send_dest_out, 32'h0011);
        begin
            int n;
            n = 0;
            while (!bus.irq_send_in && n < 60) begin cycle(); n++; end
        end
        cycle();
        check_eq("single_cmd_drop", 32'(bus.send_cmd_out),   32'd0);
        check_eq("single_done",     32'(bus.done_count_out), 32'd1);
        check_eq("single_irq",      32'(bus.irq_done_out),   32'd1);
        check_eq("single_level",    32'(bus.level_out),      32'd0);
        drain("single_drain");
        bus.irq_ack = 1'b1; cycle(); bus.irq_ack = 1'b0;

        // ---- back-to-back fill to DEPTH ----
        resp_hi = 3; resp_lo = 1;
        obs.delete();
        for (int i = 0; i < 4; i++) push_one(32'h200 + 32'(i), 32'(i + 1), 32'h20 + 32'(i));
        check_eq("full_ready", 32'(bus.push_ready), 32'd0);
        check_eq("full_level", 32'(bus.level_out),  32'd4);
        push_one(32'h2FF, 32'd9, 32'h2F);
        check_eq("full_refused_level", 32'(bus.level_out), 32'd4);
        drain("b2b_drain");
        check_eq("b2b_count", 32'(obs.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_eq("b2b_order", obs[i], 32'h200 + 32'(i));
        check_eq("b2b_done", 32'(bus.done_count_out), 32'd5);

        // ---- push in the pop cycle ----
        resp_on = 1'b0;
        obs.delete();
        push_one(32'h300, 32'd1, 32'h30);
        push_one(32'h301, 32'd2, 32'h31);
        wait_cmd("pp_wait_cmd");
        check_eq("pp_level_before", 32'(bus.level_out), 32'd2);
        bus.irq_send_in = 1'b1;
        bus.push_valid  = 1'b1;
        bus.push_addr   = 32'h302; bus.push_size = 32'd3; bus.push_dest = 32'h32;
        cycle();
        bus.push_valid  = 1'b0;
        check_eq("pp_level_after", 32'(bus.level_out), 32'd2);
        bus.irq_send_in = 1'b0;
        resp_on = 1'b1;
        drain("pp_drain");
        check_eq("pp_count", 32'(obs.size()), 32'd3);
        for (int i = 0; i < 3; i++) check_eq("pp_order", obs[i], 32'h300 + 32'(i));

        // ---- flush while the head is in flight ----
        resp_on = 1'b0;
        obs.delete();
        done_before = m_done;
        push_one(32'h400, 32'd1, 32'h40);
        push_one(32'h401, 32'd2, 32'h41);
        push_one(32'h402, 32'd3, 32'h42);
        wait_cmd("fl_wait_cmd");
        check_eq("fl_level_before", 32'(bus.level_out), 32'd3);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        check_eq("fl_level_after", 32'(bus.level_out), 32'd1);
        bus.irq_send_in = 1'b1;
        cycle();
        bus.irq_send_in = 1'b0;
        check_eq("fl_level_done", 32'(bus.level_out), 32'd0);
        resp_on = 1'b1;
        repeat (10) cycle();
        check_eq("fl_done", 32'(bus.done_count_out), 32'(done_before + 1));
        check_eq("fl_sends", 32'(obs.size()), 32'd1);

        // ---- irq set/ack race ----
        bus.irq_ack = 1'b1; cycle(); bus.irq_ack = 1'b0;
        resp_on = 1'b0;
        push_one(32'h500, 32'd5, 32'h50);
        wait_cmd("race_wait_cmd");
        bus.irq_send_in = 1'b1;
        bus.irq_ack     = 1'b1;
        cycle();
        check_eq("race_set_wins", 32'(bus.irq_done_out), 32'd1);
        bus.irq_send_in = 1'b0;
        bus.irq_ack     = 1'b0;
        cycle();
        check_eq("race_hold", 32'(bus.irq_done_out), 32'd1);
        bus.irq_ack = 1'b1;
        cycle();
        bus.irq_ack = 1'b0;
        check_eq("race_ack_clear", 32'(bus.irq_done_out), 32'd0);
        resp_on = 1'b1;
        drain("race_drain");

`ifdef DDMAQ_WATCHDOG_EN
        // ---- watchdog expiry ----
        resp_on = 1'b0;
        done_before = m_done;
        push_one(32'h600, 32'd6, 32'h60);
        push_one(32'h601, 32'd7, 32'h61);
        wait_cmd("wd_wait_cmd");
        begin
            int n;
            n = 0;
            while (bus.send_cmd_out && n < 200) begin n++; cycle(); end
            check_eq("wd_busy_cycles", 32'(n), 32'd50);
        end
        check_eq("wd_err",   32'(bus.err_out),        32'd1);
        check_eq("wd_level", 32'(bus.level_out),      32'd1);
        check_eq("wd_done",  32'(bus.done_count_out), 32'(done_before));
        check_eq("wd_irq",   32'(bus.irq_done_out),   32'd0);
        wait_cmd("wd_next_cmd");
        check_eq("wd_next_addr", bus.send_addr_out, 32'h601);
        bus.irq_send_in = 1'b1;
        cycle();
        bus.irq_send_in = 1'b0;
        resp_on = 1'b1;
        drain("wd_drain");
`endif

        // ---- randomized soak ----
        resp_on = 1'b1; resp_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            bus.push_valid = ($urandom_range(0, 1) == 1);
            bus.push_addr  = $urandom;
            bus.push_size  = $urandom;
            bus.push_dest  = $urandom;
            bus.flush      = ($urandom_range(0, 39) == 0);
            bus.irq_ack    = ($urandom_range(0, 3) == 0);
            cycle();
        end
        bus.push_valid = 1'b0;
        bus.flush      = 1'b0;
        bus.irq_ack    = 1'b0;
        drain("rand_drain");

        // ---- reset in the middle of a send ----
        resp_on = 1'b0; resp_rand = 1'b0;
        push_one(32'h700, 32'd1, 32'h70);
        push_one(32'h701, 32'd2, 32'h71);
        wait_cmd("mid_wait_cmd");
        reset = 1'b0;
        cycle();
        check_eq("mid_rst_cmd",   32'(bus.send_cmd_out), 32'd0);
        check_eq("mid_rst_level", 32'(bus.level_out),    32'd0);
        check_eq("mid_rst_addr",  bus.send_addr_out,     32'd0);
        reset = 1'b1;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
